id_stage: RTL and testbench
===========================

# id_stage

Instruction-decode stage and ID/EX pipeline register of the 5-stage MIPS core. It takes the fetched instruction and the register-file read data, and decodes them into an ALU operation code, operands and control bits. It registers that bundle for the EX stage, which drives the ALU. It also detects load-use hazards and stalls the front end, and accepts a flush from EX when a branch or jump is taken.

## Interface
- No parameters; widths are fixed at 32-bit data and 6-bit ALU op.
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  IF/ID holds a valid instruction
- id_instr  in  32  instruction word
- id_pc_plus4  in  32  PC+4 of id_instr
- id_rs_data  in  32  register-file read of instr[25:21]
- id_rt_data  in  32  register-file read of instr[20:16]
- ex_flush  in  1  EX redirects (taken BNE or J); kill ID and ID/EX contents
- id_stall  out  1  load-use stall; freeze PC and IF/ID this cycle
- ex_valid  out  1  ID/EX slot holds a live instruction
- ex_alu_op  out  6  ALU operation, codes from cpu.vh
- ex_op_a  out  32  ALU input_data1
- ex_op_b  out  32  ALU input_data2
- ex_imm  out  32  sign-extended instr[15:0]
- ex_store_data  out  32  rt data for SW
- ex_pc_plus4  out  32  registered id_pc_plus4
- ex_wb_reg  out  5  destination register
- ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump  out  1 each  control bits
- ex_illegal  out  1  unsupported opcode or funct

## Operation
Decode:
- ADD, SUB, AND, OR, XOR, SLT, MOVZ (R-type):
  - op_a = rs_data, op_b = rt_data, wb_reg = rd.
  - alu_op is the matching code.
- SLL:
  - op_a = rt_data, op_b = {27'b0, shamt}, wb_reg = rd.
- ADDI:
  - alu_op = ADD, op_a = rs_data, op_b = sext(imm), wb_reg = rt.
- LW:
  - Same operands as ADDI, with mem_read = 1.
- SW:
  - Same operands as ADDI, with mem_write = 1 and reg_write = 0.
  - store_data = rt_data.
- BNE:
  - alu_op = BNE, op_a = rs_data, op_b = rt_data, branch = 1, reg_write = 0.
- J:
  - alu_op = J, op_a = pc_plus4, op_b = {6'b0, instr[25:0]}, jump = 1, reg_write = 0.
- reg_write is forced to 0 whenever wb_reg == 0. This makes 0x00000000 a NOP.
- Any other opcode or funct:
  - ex_illegal = 1.
  - All write, memory, branch and jump bits are 0.
  - ex_valid = 1, so EX can trap on it.

Load-use hazard:
- id_stall = ex_valid & ex_mem_read & id_valid & (ex_wb_reg != 0) & match.
- match is true when ex_wb_reg equals a source register that the ID instruction actually reads:
  - rs is read by everything except SLL and J.
  - rt is read by R-type, SW and BNE.
- id_stall is combinational in the same cycle.

ID/EX update on each rising edge:
- ex_flush = 1: load a bubble and ignore the stall.
- else id_stall = 1: load a bubble. IF/ID holds, so the instruction decodes again next cycle.
- else: load the decoded bundle with ex_valid = id_valid.
- Bubble means ex_valid = 0, all control bits 0, ex_alu_op = 0, and data fields 0.

## Timing
- Decode-to-ex_* latency is one cycle. All ex_* outputs are registered.
- A load-use stall costs exactly one cycle. After the bubble, ex_mem_read is 0, so id_stall deasserts.
- ex_flush takes priority over id_stall.
- When flush and stall are asserted in the same cycle, id_stall may still be high. The front end ignores it because the flush takes effect.
- While rst_n is low, every ex_* output is 0 and id_stall is 0.
- Reset asserted mid-operation clears ID/EX immediately (asynchronous). The first edge after release loads normally.
- With id_valid = 0 there is never a stall, and a bubble is loaded.

## Configuration
- HAZARD_DETECT_EN defined: load-use detection and stall operate as described above.
- HAZARD_DETECT_EN undefined: id_stall is tied to 0 and no bubbles are inserted for loads; software must schedule a NOP after LW. Flush behaviour is unchanged.

## Structure
- cpu.vh holds all shared definitions:
  - The alu_op codes ADD, SUB, AND, OR, XOR, SLT, MOVZ, SLL, BNE, J.
  - The MIPS opcode and funct constants.
  - Instruction field bit ranges.
- Sub-module id_decoder is a combinational map from instruction to control bundle.
  - It is shared with the hazard logic's source-usage flags.
  - It has no state; the ID/EX register and hazard logic live in id_stage.

## Test plan
- ADD decode: id_instr = 0x012A4020 (add $8,$9,$10), rs_data = 5, rt_data = 7 → next cycle ex_alu_op = ADD, op_a = 5, op_b = 7, wb_reg = 8, reg_write = 1, ex_valid = 1.
- Immediate and shift decode:
  - 0x2008FFFF (addi $8,$0,-1) → op_b = ex_imm = 0xFFFFFFFF, wb_reg = 8.
  - 0x00094100 (sll $8,$9,4) with rt_data = 3 → op_a = 3, op_b = 4.
- Load-use stall:
  - 0x8D280004 (lw $8,4($9)) followed by 0x010B5020 (add $10,$8,$11) → id_stall = 1 for one cycle.
  - ID/EX then holds one bubble, and the ADD issues the following cycle.
  - With HAZARD_DETECT_EN undefined, id_stall stays 0.
- Flush during stall: apply the same LW/ADD pair, with ex_flush = 1 in the stall cycle → the next ID/EX is a bubble.
- Jump decode and NOP: 0x08000010 (j) with pc_plus4 = 0x00400008 → op_a = 0x00400008, op_b = 0x10, jump = 1. 0x00000000 → reg_write = 0.
- Illegal opcode and reset: opcode 0x3F → ex_illegal = 1 with all write bits 0. Asserting rst_n low mid-stream zeroes every output with no clock edge.

Source files
------------

// File: rtl/id_stage_pkg.sv
// Shared decode definitions for the ID stage: ALU op codes, MIPS opcode/funct
// constants, instruction field accessors and the ID/EX bundle type.
package id_stage_pkg;

    typedef enum logic [5:0] {
        ALU_NONE = 6'd0,
        ALU_ADD  = 6'd1,
        ALU_SUB  = 6'd2,
        ALU_AND  = 6'd3,
        ALU_OR   = 6'd4,
        ALU_XOR  = 6'd5,
        ALU_SLT  = 6'd6,
        ALU_MOVZ = 6'd7,
        ALU_SLL  = 6'd8,
        ALU_BNE  = 6'd9,
        ALU_J    = 6'd10
    } alu_op_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_MOVZ = 6'h0A;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    function automatic logic [5:0] f_opcode(input logic [31:0] i); return i[31:26]; endfunction
    function automatic logic [4:0] f_rs    (input logic [31:0] i); return i[25:21]; endfunction
    function automatic logic [4:0] f_rt    (input logic [31:0] i); return i[20:16]; endfunction
    function automatic logic [4:0] f_rd    (input logic [31:0] i); return i[15:11]; endfunction
    function automatic logic [4:0] f_shamt (input logic [31:0] i); return i[10:6];  endfunction
    function automatic logic [5:0] f_funct (input logic [31:0] i); return i[5:0];   endfunction
    function automatic logic [31:0] f_sext_imm(input logic [31:0] i);
        return {{16{i[15]}}, i[15:0]};
    endfunction

    typedef struct packed {
        logic        valid;
        alu_op_e     alu_op;
        logic [31:0] op_a;
        logic [31:0] op_b;
        logic [31:0] imm;
        logic [31:0] store_data;
        logic [31:0] pc_plus4;
        logic [4:0]  wb_reg;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        jump;
        logic        illegal;
    } idex_t;

    localparam idex_t IDEX_BUBBLE = '0;

endpackage

// File: rtl/id_decoder.sv
// Stateless instruction decoder: maps an instruction plus register reads to the
// ID/EX bundle and reports which source registers the instruction consumes.
module id_decoder
    import id_stage_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [31:0] pc_plus4,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output idex_t       dec,
    output logic        uses_rs,
    output logic        uses_rt
);

    logic [31:0] imm_sext;
    assign imm_sext = f_sext_imm(instr);

    // NOTE: every output gets a default before the case so no path can infer a latch.
    always_comb begin
        dec            = IDEX_BUBBLE;
        dec.valid      = 1'b1;
        dec.imm        = imm_sext;
        dec.pc_plus4   = pc_plus4;
        dec.store_data = rt_data;
        uses_rs        = 1'b0;
        uses_rt        = 1'b0;

        unique case (f_opcode(instr))
            OP_RTYPE: begin
                dec.op_a      = rs_data;
                dec.op_b      = rt_data;
                dec.wb_reg    = f_rd(instr);
                dec.reg_write = 1'b1;
                uses_rs       = 1'b1;
                uses_rt       = 1'b1;
                unique case (f_funct(instr))
                    FN_ADD:  dec.alu_op = ALU_ADD;
                    FN_SUB:  dec.alu_op = ALU_SUB;
                    FN_AND:  dec.alu_op = ALU_AND;
                    FN_OR:   dec.alu_op = ALU_OR;
                    FN_XOR:  dec.alu_op = ALU_XOR;
                    FN_SLT:  dec.alu_op = ALU_SLT;
                    FN_MOVZ: dec.alu_op = ALU_MOVZ;
                    FN_SLL: begin
                        dec.alu_op = ALU_SLL;
                        dec.op_a   = rt_data;
                        dec.op_b   = {27'b0, f_shamt(instr)};
                        uses_rs    = 1'b0;
                    end
                    default: begin
                        dec.op_a      = '0;
                        dec.op_b      = '0;
                        dec.wb_reg    = '0;
                        dec.reg_write = 1'b0;
                        dec.illegal   = 1'b1;
                        uses_rs       = 1'b0;
                        uses_rt       = 1'b0;
                    end
                endcase
            end
            OP_ADDI, OP_LW, OP_SW: begin
                dec.alu_op = ALU_ADD;
                dec.op_a   = rs_data;
                dec.op_b   = imm_sext;
                dec.wb_reg = f_rt(instr);
                uses_rs    = 1'b1;
                if (f_opcode(instr) == OP_SW) begin
                    dec.mem_write = 1'b1;
                    uses_rt       = 1'b1;
                end else begin
                    dec.reg_write = 1'b1;
                    dec.mem_read  = (f_opcode(instr) == OP_LW);
                end
            end
            OP_BNE: begin
                dec.alu_op = ALU_BNE;
                dec.op_a   = rs_data;
                dec.op_b   = rt_data;
                dec.branch = 1'b1;
                uses_rs    = 1'b1;
                uses_rt    = 1'b1;
            end
            OP_J: begin
                dec.alu_op = ALU_J;
                dec.op_a   = pc_plus4;
                dec.op_b   = {6'b0, instr[25:0]};
                dec.jump   = 1'b1;
            end
            default: dec.illegal = 1'b1;
        endcase

        // Writes to $0 are discarded, which turns the all-zero word into a NOP.
        if (dec.wb_reg == 5'd0)
            dec.reg_write = 1'b0;
    end

endmodule

// File: rtl/id_stage.sv
// ID stage with ID/EX pipeline register, load-use stall and EX flush.
// Load-use detection is built only when HAZARD_DETECT_EN is defined.
module id_stage
    import id_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic [31:0] id_instr,
    input  logic [31:0] id_pc_plus4,
    input  logic [31:0] id_rs_data,
    input  logic [31:0] id_rt_data,
    input  logic        ex_flush,
    output logic        id_stall,
    output logic        ex_valid,
    output logic [5:0]  ex_alu_op,
    output logic [31:0] ex_op_a,
    output logic [31:0] ex_op_b,
    output logic [31:0] ex_imm,
    output logic [31:0] ex_store_data,
    output logic [31:0] ex_pc_plus4,
    output logic [4:0]  ex_wb_reg,
    output logic        ex_reg_write,
    output logic        ex_mem_read,
    output logic        ex_mem_write,
    output logic        ex_branch,
    output logic        ex_jump,
    output logic        ex_illegal
);

    idex_t dec;
    idex_t idex_q;
    logic  uses_rs;
    logic  uses_rt;

    id_decoder u_decoder (
        .instr    (id_instr),
        .pc_plus4 (id_pc_plus4),
        .rs_data  (id_rs_data),
        .rt_data  (id_rt_data),
        .dec      (dec),
        .uses_rs  (uses_rs),
        .uses_rt  (uses_rt)
    );

`ifdef HAZARD_DETECT_EN
    logic src_match;
    assign src_match = (uses_rs && (f_rs(id_instr) == idex_q.wb_reg)) ||
                       (uses_rt && (f_rt(id_instr) == idex_q.wb_reg));
    assign id_stall  = idex_q.valid && idex_q.mem_read && id_valid &&
                       (idex_q.wb_reg != 5'd0) && src_match;
`else
    logic unused_src_flags;
    assign unused_src_flags = uses_rs ^ uses_rt;
    assign id_stall         = 1'b0;
`endif

    // NOTE: non-blocking assignments for all state; the async reset clears the whole bundle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_q <= IDEX_BUBBLE;
        end else if (ex_flush || id_stall || !id_valid) begin
            idex_q <= IDEX_BUBBLE;
        end else begin
            idex_q <= dec;
        end
    end

    assign ex_valid      = idex_q.valid;
    assign ex_alu_op     = idex_q.alu_op;
    assign ex_op_a       = idex_q.op_a;
    assign ex_op_b       = idex_q.op_b;
    assign ex_imm        = idex_q.imm;
    assign ex_store_data = idex_q.store_data;
    assign ex_pc_plus4   = idex_q.pc_plus4;
    assign ex_wb_reg     = idex_q.wb_reg;
    assign ex_reg_write  = idex_q.reg_write;
    assign ex_mem_read   = idex_q.mem_read;
    assign ex_mem_write  = idex_q.mem_write;
    assign ex_branch     = idex_q.branch;
    assign ex_jump       = idex_q.jump;
    assign ex_illegal    = idex_q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Directed self-checking bench for id_stage; stall expectations follow HAZARD_DETECT_EN.
module tb_id_stage;
    import id_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc_plus4;
    logic [31:0] id_rs_data;
    logic [31:0] id_rt_data;
    logic        ex_flush;
    logic        id_stall;
    logic        ex_valid;
    logic [5:0]  ex_alu_op;
    logic [31:0] ex_op_a;
    logic [31:0] ex_op_b;
    logic [31:0] ex_imm;
    logic [31:0] ex_store_data;
    logic [31:0] ex_pc_plus4;
    logic [4:0]  ex_wb_reg;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        ex_branch;
    logic        ex_jump;
    logic        ex_illegal;

    int n_cmp = 0;
    int n_err = 0;

`ifdef HAZARD_DETECT_EN
    localparam logic HAZ = 1'b1;
`else
    localparam logic HAZ = 1'b0;
`endif

    id_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .id_valid      (id_valid),
        .id_instr      (id_instr),
        .id_pc_plus4   (id_pc_plus4),
        .id_rs_data    (id_rs_data),
        .id_rt_data    (id_rt_data),
        .ex_flush      (ex_flush),
        .id_stall      (id_stall),
        .ex_valid      (ex_valid),
        .ex_alu_op     (ex_alu_op),
        .ex_op_a       (ex_op_a),
        .ex_op_b       (ex_op_b),
        .ex_imm        (ex_imm),
        .ex_store_data (ex_store_data),
        .ex_pc_plus4   (ex_pc_plus4),
        .ex_wb_reg     (ex_wb_reg),
        .ex_reg_write  (ex_reg_write),
        .ex_mem_read   (ex_mem_read),
        .ex_mem_write  (ex_mem_write),
        .ex_branch     (ex_branch),
        .ex_jump       (ex_jump),
        .ex_illegal    (ex_illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                         input logic [31:0] rs, input logic [31:0] rt);
        @(negedge clk);
        id_valid    = v;
        id_instr    = instr;
        id_pc_plus4 = pc;
        id_rs_data  = rs;
        id_rt_data  = rt;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; id_valid = 1'b0; id_instr = '0; id_pc_plus4 = '0;
        id_rs_data = '0; id_rt_data = '0; ex_flush = 1'b0;
        #3;
        chk("rst_valid", 32'(ex_valid), 32'd0);
        chk("rst_stall", 32'(id_stall), 32'd0);
        chk("rst_alu_op", 32'(ex_alu_op), 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // add $8,$9,$10
        drive(1'b1, 32'h012A4020, 32'h0000_0100, 32'd5, 32'd7);
        tick();
        chk("add_valid", 32'(ex_valid), 32'd1);
        chk("add_alu_op", 32'(ex_alu_op), 32'(ALU_ADD));
        chk("add_op_a", ex_op_a, 32'd5);
        chk("add_op_b", ex_op_b, 32'd7);
        chk("add_wb_reg", 32'(ex_wb_reg), 32'd8);
        chk("add_reg_write", 32'(ex_reg_write), 32'd1);
        chk("add_pc_plus4", ex_pc_plus4, 32'h0000_0100);

        // addi $8,$0,-1
        drive(1'b1, 32'h2008FFFF, 32'h0000_0104, 32'd0, 32'd9);
        tick();
        chk("addi_op_b", ex_op_b, 32'hFFFF_FFFF);
        chk("addi_imm", ex_imm, 32'hFFFF_FFFF);
        chk("addi_wb_reg", 32'(ex_wb_reg), 32'd8);
        chk("addi_alu_op", 32'(ex_alu_op), 32'(ALU_ADD));

        // sll $8,$9,4
        drive(1'b1, 32'h00094100, 32'h0000_0108, 32'd77, 32'd3);
        tick();
        chk("sll_alu_op", 32'(ex_alu_op), 32'(ALU_SLL));
        chk("sll_op_a", ex_op_a, 32'd3);
        chk("sll_op_b", ex_op_b, 32'd4);
        chk("sll_wb_reg", 32'(ex_wb_reg), 32'd8);

        // lw $8,4($9) then add $10,$8,$11
        drive(1'b1, 32'h8D280004, 32'h0000_010C, 32'h0000_1000, 32'd0);
        tick();
        chk("lw_mem_read", 32'(ex_mem_read), 32'd1);
        chk("lw_op_a", ex_op_a, 32'h0000_1000);
        chk("lw_op_b", ex_op_b, 32'd4);
        chk("lw_reg_write", 32'(ex_reg_write), 32'd1);
        drive(1'b1, 32'h010B5020, 32'h0000_0110, 32'd20, 32'd30);
        #1;
        chk("lu_stall", 32'(id_stall), 32'(HAZ));
        tick();
        chk("lu_after1_valid", 32'(ex_valid), HAZ ? 32'd0 : 32'd1);
        chk("lu_after1_op_a", ex_op_a, HAZ ? 32'd0 : 32'd20);
        chk("lu_after1_mem_read", 32'(ex_mem_read), 32'd0);
        chk("lu_after1_stall", 32'(id_stall), 32'd0);
        if (HAZ) begin
            tick();
            chk("lu_issue_valid", 32'(ex_valid), 32'd1);
            chk("lu_issue_op_a", ex_op_a, 32'd20);
            chk("lu_issue_op_b", ex_op_b, 32'd30);
            chk("lu_issue_wb_reg", 32'(ex_wb_reg), 32'd10);
        end

        // lw again; id_valid low never stalls; then flush in the stall cycle
        drive(1'b1, 32'h8D280004, 32'h0000_0200, 32'h0000_1000, 32'd0);
        tick();
        drive(1'b0, 32'h010B5020, 32'h0000_0204, 32'd20, 32'd30);
        #1;
        chk("novalid_stall", 32'(id_stall), 32'd0);
        id_valid = 1'b1;
        ex_flush = 1'b1;
        #1;
        chk("flush_stall_seen", 32'(id_stall), 32'(HAZ));
        tick();
        chk("flush_valid", 32'(ex_valid), 32'd0);
        chk("flush_alu_op", 32'(ex_alu_op), 32'd0);
        chk("flush_op_a", ex_op_a, 32'd0);
        drive(1'b0, 32'h012A4020, 32'h0000_0300, 32'd1, 32'd2);
        ex_flush = 1'b0;
        tick();
        chk("idle_valid", 32'(ex_valid), 32'd0);
        chk("idle_stall", 32'(id_stall), 32'd0);

        // j 0x10
        drive(1'b1, 32'h08000010, 32'h0040_0008, 32'd1, 32'd2);
        tick();
        chk("j_alu_op", 32'(ex_alu_op), 32'(ALU_J));
        chk("j_op_a", ex_op_a, 32'h0040_0008);
        chk("j_op_b", ex_op_b, 32'h0000_0010);
        chk("j_jump", 32'(ex_jump), 32'd1);
        chk("j_reg_write", 32'(ex_reg_write), 32'd0);

        // NOP
        drive(1'b1, 32'h00000000, 32'h0040_000C, 32'd1, 32'd2);
        tick();
        chk("nop_valid", 32'(ex_valid), 32'd1);
        chk("nop_reg_write", 32'(ex_reg_write), 32'd0);
        chk("nop_illegal", 32'(ex_illegal), 32'd0);

        // bne $9,$10,3
        drive(1'b1, 32'h152A0003, 32'h0040_0010, 32'd1, 32'd2);
        tick();
        chk("bne_alu_op", 32'(ex_alu_op), 32'(ALU_BNE));
        chk("bne_branch", 32'(ex_branch), 32'd1);
        chk("bne_op_b", ex_op_b, 32'd2);
        chk("bne_reg_write", 32'(ex_reg_write), 32'd0);

        // sw $8,8($9)
        drive(1'b1, 32'hAD280008, 32'h0040_0014, 32'h0000_0200, 32'h0000_DEAD);
        tick();
        chk("sw_mem_write", 32'(ex_mem_write), 32'd1);
        chk("sw_reg_write", 32'(ex_reg_write), 32'd0);
        chk("sw_store_data", ex_store_data, 32'h0000_DEAD);
        chk("sw_op_a", ex_op_a, 32'h0000_0200);
        chk("sw_op_b", ex_op_b, 32'd8);

        // sub $8,$9,$10
        drive(1'b1, 32'h012A4022, 32'h0040_0018, 32'd10, 32'd3);
        tick();
        chk("sub_alu_op", 32'(ex_alu_op), 32'(ALU_SUB));

        // illegal opcode 0x3F
        drive(1'b1, 32'hFC000000, 32'h0040_001C, 32'd1, 32'd2);
        tick();
        chk("ill_illegal", 32'(ex_illegal), 32'd1);
        chk("ill_valid", 32'(ex_valid), 32'd1);
        chk("ill_reg_write", 32'(ex_reg_write), 32'd0);
        chk("ill_mem_write", 32'(ex_mem_write), 32'd0);
        chk("ill_mem_read", 32'(ex_mem_read), 32'd0);

        // asynchronous reset mid-stream
        drive(1'b1, 32'h012A4020, 32'h0040_0020, 32'd5, 32'd7);
        tick();
        chk("pre_rst_valid", 32'(ex_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(ex_valid), 32'd0);
        chk("arst_op_a", ex_op_a, 32'd0);
        chk("arst_reg_write", 32'(ex_reg_write), 32'd0);
        chk("arst_pc_plus4", ex_pc_plus4, 32'd0);
        chk("arst_stall", 32'(id_stall), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        tick();
        chk("post_rst_valid", 32'(ex_valid), 32'd1);
        chk("post_rst_op_b", ex_op_b, 32'd7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
